// File: rtl/mochila_bank_arbiter.sv
// Round-robin OBI arbiter sharing one single-port SRAM bank, 1-cycle read latency.
// Optional out-of-bank error responses: define MOCHILA_BANK_ARB_RANGE_CHK_EN.
module mochila_bank_arbiter #(
  parameter int NUM_REQ = 7,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] BANK_BASE = 32'hF0100000,
  parameter logic [ADDR_W-1:0] BANK_SIZE = 32'h00008000
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0]                  we_i,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]       be_i,
  input  logic [NUM_REQ*ADDR_W-1:0]           addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]           wdata_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic [NUM_REQ-1:0]                  rvalid_o,
  output logic [NUM_REQ-1:0]                  err_o,
  output logic [DATA_W-1:0]                   rdata_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [DATA_W/8-1:0]                 mem_be_o,
  output logic [$clog2(BANK_SIZE/4)-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]                   mem_wdata_o,
  input  logic [DATA_W-1:0]                   mem_rdata_i
);

  localparam int BW = DATA_W / 8;
  localparam int AW = $clog2(BANK_SIZE / 4);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
  localparam logic [DATA_W-1:0] ERR_PAT = DATA_W'(32'hBADACCE5);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          resp_vld_q, resp_vld_d;
  logic [PW-1:0] resp_idx_q, resp_idx_d;
  logic          resp_err_q, resp_err_d;

  logic              gnt_any;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     scan_idx;
  int                scan_j;
  logic [ADDR_W-1:0] sel_addr;
  logic              range_err;

  // first requester at or above the pointer, wrapping
  always_comb begin
    gnt_any  = 1'b0;
    sel      = '0;
    scan_j   = 0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_j = int'(rr_ptr_q) + i;
      if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
      scan_idx = PW'(scan_j);
      if (!gnt_any && req_i[scan_idx]) begin
        gnt_any = 1'b1;
        sel     = scan_idx;
      end
    end
    if (!rst_ni) gnt_any = 1'b0;
  end

  always_comb begin
    sel_addr = addr_i[int'(sel)*ADDR_W +: ADDR_W];
`ifdef MOCHILA_BANK_ARB_RANGE_CHK_EN
    range_err = gnt_any && !((sel_addr - BANK_BASE) < BANK_SIZE);
`else
    range_err = 1'b0;
`endif
  end

  always_comb begin
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_any) begin
      gnt_o[sel]  = 1'b1;
      mem_req_o   = !range_err;
      mem_we_o    = we_i[sel];
      mem_be_o    = be_i[int'(sel)*BW +: BW];
      mem_addr_o  = AW'((sel_addr - BANK_BASE) >> 2);
      mem_wdata_o = wdata_i[int'(sel)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) rr_ptr_d = (sel == LAST) ? '0 : sel + 1'b1;
    resp_vld_d = gnt_any;
    resp_idx_d = sel;
    resp_err_d = range_err;
  end

  // a response pending across reset is suppressed here
  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    if (rst_ni && resp_vld_q) begin
      rvalid_o[resp_idx_q] = 1'b1;
      err_o[resp_idx_q]    = resp_err_q;
      rdata_o              = resp_err_q ? ERR_PAT : mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      resp_vld_q <= 1'b0;
      resp_idx_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      resp_vld_q <= resp_vld_d;
      resp_idx_q <= resp_idx_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_mochila_bank_arbiter.sv
// Scoreboard bench for mochila_bank_arbiter: directed plus random OBI traffic.
// Expectations follow MOCHILA_BANK_ARB_RANGE_CHK_EN when it is defined.
module tb_mochila_bank_arbiter;
  localparam int NR = 7;
  localparam int IW = 3;
  localparam logic [31:0] BASE = 32'hF0100000;
  localparam logic [31:0] SIZE = 32'h00008000;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [NR-1:0]    req_i, we_i, gnt_o, rvalid_o, err_o;
  logic [NR*4-1:0]  be_i;
  logic [NR*32-1:0] addr_i, wdata_i;
  logic [31:0]      rdata_o, mem_wdata_o;
  logic [31:0]      mem_rdata_i = 32'h0;
  logic             mem_req_o, mem_we_o;
  logic [3:0]       mem_be_o;
  logic [12:0]      mem_addr_o;

  mochila_bank_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int idx;
    int cyc;
    bit err;
    bit chkd;
    logic [31:0] rd;
  } item_t;

  item_t sb[$];
  logic [31:0] gold [int];
  logic [31:0] sram [int];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ptr = 0;
  logic [NR-1:0] granted = '0;

  logic [NR-1:0] r_req, r_we;
  logic [3:0]    r_be [NR];
  logic [31:0]   r_addr [NR];
  logic [31:0]   r_wd [NR];

  always_comb begin
    req_i = r_req;
    we_i  = r_we;
    be_i = '0;
    addr_i = '0;
    wdata_i = '0;
    for (int k = 0; k < NR; k++) begin
      be_i[k*4 +: 4]     = r_be[k];
      addr_i[k*32 +: 32] = r_addr[k];
      wdata_i[k*32 +: 32] = r_wd[k];
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", n, a, e, cyc);
    end
  endtask

  function automatic logic [31:0] gold_rd(input int a);
    return gold.exists(a) ? gold[a] : 32'h0;
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // SRAM macro model
  initial forever begin
    int s_a;
    logic [31:0] s_w;
    @(posedge clk_i);
    if (mem_req_o) begin
      s_a = int'(mem_addr_o);
      s_w = sram.exists(s_a) ? sram[s_a] : 32'h0;
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) s_w[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
        sram[s_a] = s_w;
      end else begin
        mem_rdata_i <= s_w;
      end
    end
  end

  // reference model: decide the grant, check request-side outputs, queue response
  initial forever begin
    int m_w, m_word;
    bit m_err;
    logic [31:0] m_off, g;
    logic [NR-1:0] exp_g;
    item_t it;
    @(negedge clk_i);
    if (!rst_ni) begin
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      chk("rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("rst_mem_req", 64'(mem_req_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_rdata", 64'(rdata_o), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
      sb.delete();
      ptr = 0;
      granted = '0;
    end else begin
      m_w = -1;
      for (int i = 0; i < NR; i++)
        if (m_w < 0 && r_req[IW'((ptr + i) % NR)]) m_w = (ptr + i) % NR;
      exp_g = '0;
      if (m_w >= 0) exp_g[IW'(m_w)] = 1'b1;
      chk("gnt", 64'(gnt_o), 64'(exp_g));
      granted = exp_g;
      if (m_w < 0) begin
        chk("idle_mem_req", 64'(mem_req_o), 64'd0);
      end else begin
        m_off = r_addr[IW'(m_w)] - BASE;
        m_word = int'((m_off >> 2) & (SIZE / 4 - 1));
`ifdef MOCHILA_BANK_ARB_RANGE_CHK_EN
        m_err = (m_off >= SIZE);
`else
        m_err = 1'b0;
`endif
        chk("mem_req", 64'(mem_req_o), 64'(!m_err));
        it.idx = m_w;
        it.cyc = cyc;
        it.err = m_err;
        it.chkd = m_err || !r_we[IW'(m_w)];
        it.rd = m_err ? 32'hBADACCE5 : gold_rd(m_word);
        if (!m_err) begin
          chk("mem_addr", 64'(mem_addr_o), 64'(m_word));
          chk("mem_we", 64'(mem_we_o), 64'(r_we[IW'(m_w)]));
          if (r_we[IW'(m_w)]) begin
            chk("mem_be", 64'(mem_be_o), 64'(r_be[IW'(m_w)]));
            chk("mem_wdata", 64'(mem_wdata_o), 64'(r_wd[IW'(m_w)]));
            g = gold_rd(m_word);
            for (int b = 0; b < 4; b++)
              if (r_be[IW'(m_w)][b]) g[b*8 +: 8] = r_wd[IW'(m_w)][b*8 +: 8];
            gold[m_word] = g;
          end
        end
        sb.push_back(it);
        ptr = (m_w == NR - 1) ? 0 : m_w + 1;
      end
    end
  end

  // response monitor
  initial forever begin
    item_t mi;
    logic [NR-1:0] mexp;
    @(negedge clk_i);
    if (rst_ni) begin
      if (rvalid_o != '0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rv_unexpected act=%b exp=none cyc=%0d", rvalid_o, cyc);
        end else begin
          mi = sb.pop_front();
          mexp = '0;
          mexp[IW'(mi.idx)] = 1'b1;
          chk("rv_onehot", 64'(rvalid_o), 64'(mexp));
          chk("rv_latency", 64'(cyc), 64'(mi.cyc + 1));
          chk("rv_err", 64'(err_o), mi.err ? 64'(mexp) : 64'd0);
          if (mi.chkd) chk("rdata", 64'(rdata_o), 64'(mi.rd));
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL rv_missing act=0 exp_idx=%0d cyc=%0d", sb[0].idx, cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    r_req = r_req & ~granted;
  endtask

  task automatic issue(input int k, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    r_req[IW'(k)] = 1'b1;
    r_we[IW'(k)]  = we;
    r_addr[IW'(k)] = a;
    r_wd[IW'(k)]  = d;
    r_be[IW'(k)]  = be;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (r_req != '0 && n < 60) begin
      step();
      n++;
    end
    step();
    step();
  endtask

  task automatic do_reset(input int n);
    rst_ni = 1'b0;
    r_req = '0;
    repeat (n) step();
    rst_ni = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int s;
    s = int'($urandom_range(99));
    if (s < 70) return BASE + 32'($urandom_range(15)) * 4;
    if (s < 85) return BASE + {17'd0, 13'($urandom), 2'b00};
    if (s < 93) return BASE + SIZE + 32'($urandom_range(15)) * 4;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    r_req = '0;
    r_we = '0;
    for (int k = 0; k < NR; k++) begin
      r_be[k] = '0;
      r_addr[k] = '0;
      r_wd[k] = '0;
    end
    do_reset(3);
    // write then read back through requester 0
    issue(0, 1'b1, 32'hF0100010, 32'hCAFE0001, 4'hF);
    drain();
    issue(0, 1'b0, 32'hF0100010, 32'h0, 4'hF);
    drain();
    // everyone requesting for 14 cycles
    do_reset(2);
    repeat (14) begin
      for (int k = 0; k < NR; k++)
        if (!r_req[IW'(k)]) issue(k, 1'b0, BASE + 32'(k * 4), 32'h0, 4'hF);
      step();
    end
    drain();
    // pointer at 3, requesters 2 and 5 collide
    do_reset(2);
    issue(2, 1'b0, BASE, 32'h0, 4'hF);
    drain();
    issue(2, 1'b1, BASE + 32'h20, 32'h0000_2222, 4'h3);
    issue(5, 1'b1, BASE + 32'h24, 32'h5555_0000, 4'hC);
    drain();
    // 6 then 0: response and grant share a cycle
    issue(6, 1'b0, BASE + 32'h20, 32'h0, 4'hF);
    step();
    issue(0, 1'b0, BASE + 32'h24, 32'h0, 4'hF);
    drain();
    // reset right after a read grant to 4
    issue(4, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    step();
    rst_ni = 1'b0;
    r_req = '0;
    step();
    step();
    rst_ni = 1'b1;
    issue(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    issue(4, 1'b0, BASE + 32'h14, 32'h0, 4'hF);
    drain();
    // just past the bank end, read and write
    issue(1, 1'b0, 32'hF0108000, 32'h0, 4'hF);
    drain();
    issue(3, 1'b1, 32'hF0108004, 32'h1234_5678, 4'hF);
    drain();
    issue(3, 1'b0, 32'hF0100004, 32'h0, 4'hF);
    drain();
    // random traffic with occasional resets
    repeat (600) begin
      if ($urandom_range(99) == 0) begin
        rst_ni = 1'b0;
        r_req = '0;
        step();
        step();
        rst_ni = 1'b1;
      end
      for (int k = 0; k < NR; k++)
        if (!r_req[IW'(k)] && $urandom_range(99) < 40)
          issue(k, 1'($urandom_range(1)), rnd_addr(), $urandom, 4'($urandom));
      step();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
